// File: rtl/ff_bank.sv
// ----------------------------------------------------------------------------
// ff_bank
// N independent single-bit storage channels, all clocked on the rising edge of
// clk. A runtime mode selects D, T, JK or SR behaviour for every channel. An SR
// channel with both S and R high does not change its state. Each such channel
// sets a sticky error flag, and every edge that has at least one of them adds
// one to a saturating counter.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-high reset
//   en       in   1      update enable (0 = q/err/err_cnt hold, chg = 0)
//   mode     in   2      00 D, 01 T, 10 JK, 11 SR
//   a        in   N      D / T / J / S per channel
//   b        in   N      unused / unused / K / R per channel
//   clr_err  in   1      synchronous clear of err and err_cnt
//   q        out  N      registered state
//   qn       out  N      ~q
//   chg      out  N      one-cycle pulse: q[i] changed on the last edge
//   err      out  N      sticky per-channel illegal-SR flag
//   err_cnt  out  CNT_W  saturating count of edges with any illegal channel
// ----------------------------------------------------------------------------
module ff_bank #(
    parameter int              N         = 8,
    parameter int              CNT_W     = 8,
    parameter logic [N-1:0]    RESET_VAL = {N{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             clr_err,
    output logic [N-1:0]     q,
    output logic [N-1:0]     qn,
    output logic [N-1:0]     chg,
    output logic [N-1:0]     err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N-1:0] q_next;
    logic [N-1:0] illegal;
    logic         any_illegal;

    // Next state and illegal detection. When en is low, q_next equals q and no
    // channel is flagged. That one rule makes q, chg, err and err_cnt all
    // behave correctly without gating each register separately.
    always_comb begin
        q_next  = q;
        illegal = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                unique case (mode)
                    MODE_D:  q_next[i] = a[i];
                    MODE_T:  q_next[i] = q[i] ^ a[i];
                    MODE_JK: begin
                        unique case ({a[i], b[i]})
                            2'b00:   q_next[i] = q[i];
                            2'b10:   q_next[i] = 1'b1;
                            2'b01:   q_next[i] = 1'b0;
                            default: q_next[i] = ~q[i];
                        endcase
                    end
                    default: begin // MODE_SR
                        unique case ({a[i], b[i]})
                            2'b00:   q_next[i] = q[i];
                            2'b10:   q_next[i] = 1'b1;
                            2'b01:   q_next[i] = 1'b0;
                            default: begin
                                // S=R=1: q holds its value instead of going
                                // to X, and the channel is flagged.
                                q_next[i]  = q[i];
                                illegal[i] = 1'b1;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    assign any_illegal = |illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= RESET_VAL;
            chg     <= '0;
            err     <= '0;
            err_cnt <= '0;
        end else begin
            q   <= q_next;
            chg <= q_next ^ q;

            // If a clear and a new illegal event arrive on the same edge, the
            // new event wins. err then holds only this edge's illegal channels
            // and the count restarts at 1.
            if (clr_err) begin
                err     <= illegal;
                err_cnt <= any_illegal ? CNT_ONE : '0;
            end else begin
                err <= err | illegal;
                if (any_illegal && (err_cnt != CNT_MAX)) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end
        end
    end

    assign qn = ~q;

endmodule

// File: tb/tb_ff_bank.sv
// ----------------------------------------------------------------------------
// tb_ff_bank
// Directed bench for ff_bank. u_dut uses the default parameters. u_sat shares
// every input with u_dut but has CNT_W=2 and RESET_VAL=8'h5A, so it shows
// counter saturation and a non-zero reset value. Inputs change 1 time unit
// after each rising edge. Outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_ff_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_err;

    logic [7:0] q, qn, chg, err, err_cnt;
    logic [7:0] q_s, qn_s, chg_s, err_s;
    logic [1:0] cnt_s;

    int checks = 0;
    int errors = 0;

    // Expected-value queue for the D-mode burst.
    logic [7:0] exp_q[$];

    ff_bank #(.N(8), .CNT_W(8), .RESET_VAL(8'h00)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .q(q), .qn(qn), .chg(chg), .err(err),
        .err_cnt(err_cnt)
    );

    ff_bank #(.N(8), .CNT_W(2), .RESET_VAL(8'h5A)) u_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .q(q_s), .qn(qn_s), .chg(chg_s), .err(err_s),
        .err_cnt(cnt_s)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] m,
                         input logic [7:0] av, input logic [7:0] bv,
                         input logic c);
        en      = e;
        mode    = m;
        a       = av;
        b       = bv;
        clr_err = c;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        #3;
        chk("rst_q",     q,       8'h00);
        chk("rst_qn",    qn,      8'hFF);
        chk("rst_chg",   chg,     8'h00);
        chk("rst_err",   err,     8'h00);
        chk("rst_cnt",   err_cnt, 8'h00);
        chk("rst_q_sat", q_s,     8'h5A);
        chk("rst_cnt_s", cnt_s,   2'd0);

        step();
        rst = 1'b0;

        // D mode
        drive(1'b1, 2'b00, 8'hA5, 8'h00, 1'b0);
        step();
        chk("d_q",   q,   8'hA5);
        chk("d_qn",  qn,  8'h5A);
        chk("d_chg", chg, 8'hA5);
        step();
        chk("d_chg_same", chg, 8'h00);

        // T mode: A5 ^ 0F = AA
        drive(1'b1, 2'b01, 8'h0F, 8'h00, 1'b0);
        step();
        chk("t_q",   q,   8'hAA);
        chk("t_chg", chg, 8'h0F);

        // en=0 holds for 3 edges
        drive(1'b0, 2'b01, 8'hFF, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_q",   q,   8'hAA);
            chk("hold_chg", chg, 8'h00);
        end

        // JK from AA with J=F0, K=3C:
        //   ch7:6 J1K0 set -> 11, ch5:4 J1K1 toggle 10 -> 01,
        //   ch3:2 J0K1 clear -> 00, ch1:0 J0K0 hold -> 10  => 1101_0010 = D2
        drive(1'b1, 2'b10, 8'hF0, 8'h3C, 1'b0);
        step();
        chk("jk_q",   q,   8'hD2);
        chk("jk_chg", chg, 8'h78);

        // SR clear all channels, then drive the illegal pattern
        drive(1'b1, 2'b11, 8'h00, 8'hFF, 1'b0);
        step();
        chk("sr_clr_q", q,   8'h00);
        chk("sr_clr_e", err, 8'h00);

        drive(1'b1, 2'b11, 8'h03, 8'h01, 1'b0);
        step();
        chk("sr_ill_q",   q,       8'h02);
        chk("sr_ill_err", err,     8'h01);
        chk("sr_ill_cnt", err_cnt, 8'd1);
        chk("sr_ill_cs",  cnt_s,   2'd1);
        step();
        step();
        chk("sr_rep_q",   q,       8'h02);
        chk("sr_rep_err", err,     8'h01);
        chk("sr_rep_cnt", err_cnt, 8'd3);
        chk("sr_rep_chg", chg,     8'h00);
        chk("sr_rep_cs",  cnt_s,   2'd3);

        // clear on the same edge as a new illegal ch7: the new event wins
        drive(1'b1, 2'b11, 8'h80, 8'h80, 1'b1);
        step();
        chk("coll_err", err,     8'h80);
        chk("coll_cnt", err_cnt, 8'd1);
        chk("coll_cs",  cnt_s,   2'd1);
        chk("coll_q",   q,       8'h02);

        // 5 consecutive illegal edges: 2-bit counter saturates at 3
        drive(1'b1, 2'b11, 8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("sat_cs",  cnt_s,   2'd3);
        chk("sat_cnt", err_cnt, 8'd6);
        chk("sat_err", err,     8'h80);

        // every channel illegal on one edge still counts once
        drive(1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("all_ill_cnt", err_cnt, 8'd7);
        chk("all_ill_err", err,     8'hFF);
        chk("all_ill_q",   q,       8'h02);

        // en=0 with clr_err: the clear still happens, nothing is flagged
        drive(1'b0, 2'b11, 8'hFF, 8'hFF, 1'b1);
        step();
        chk("en0_clr_err", err,     8'h00);
        chk("en0_clr_cnt", err_cnt, 8'd0);
        chk("en0_clr_q",   q,       8'h02);
        chk("en0_clr_chg", chg,     8'h00);

        // a=b=1 is legal in D, T and JK modes
        drive(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("d_ab1_q",   q,       8'hFF);
        drive(1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("t_ab1_q",   q,       8'h00);
        drive(1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("jk_ab1_q",   q,       8'hFF);
        chk("jk_ab1_err", err,     8'h00);
        chk("jk_ab1_cnt", err_cnt, 8'd0);

        // err stays set across a mode change
        drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b0);
        step();
        chk("stk_err0", err, 8'h01);
        drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
        step();
        chk("stk_q",    q,   8'h00);
        chk("stk_err1", err, 8'h01);

        // D-mode burst checked through the expected queue
        foreach (exp_q[i]) exp_q.delete(i);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] v;
            v = 8'h11 << i;
            drive(1'b1, 2'b00, v, 8'h00, 1'b0);
            exp_q.push_back(v);
            step();
            chk("burst_q", q, exp_q.pop_front());
        end

        // asynchronous reset between edges
        drive(1'b1, 2'b00, 8'hF6, 8'h00, 1'b0);
        step();
        chk("pre_rst_q",   q,   8'hF6);
        chk("pre_rst_err", err, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_q",     q,       8'h00);
        chk("arst_qn",    qn,      8'hFF);
        chk("arst_chg",   chg,     8'h00);
        chk("arst_err",   err,     8'h00);
        chk("arst_cnt",   err_cnt, 8'd0);
        chk("arst_q_sat", q_s,     8'h5A);
        step();
        chk("arst_hold_q", q, 8'h00);
        rst = 1'b0;
        drive(1'b1, 2'b00, 8'h3C, 8'h00, 1'b0);
        step();
        chk("post_rst_q",   q,   8'h3C);
        chk("post_rst_chg", chg, 8'h3C);

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Upper bound on run time, in case the sequence stalls.
    initial begin
        #100000;
        $display("FAIL timeout: sequence did not complete");
        $fatal(1, "timeout");
    end

endmodule
